clk_div_wiz: RTL and testbench

- Parametrised behavioral clock generator for simulation. Successor to the fixed divide-by-2 model.
- Produces NUM_CH output clocks from clk_in1. Each output runs at an even ratio clk_in1/(2*half[i]).
- Half-period counts can be reprogrammed at runtime through a valid/ready config port. A lock counter models PLL lock time.
- Sits in verif/ in place of vendor clock wizards. Testbench and SoC clock consumers see the same lock/reconfig semantics as the hardware.

---
 rtl/clk_div_wiz_pkg.sv | 21 ++
 rtl/clk_div_wiz_chan.sv | 50 +++++
 rtl/clk_div_wiz.sv | 110 +++++++++++
 tb/tb_clk_div_wiz.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_wiz_pkg.sv
// ============================================================================
// clk_div_wiz_pkg : shared state encoding and helpers for clk_div_wiz
// Revision: 1.0
// ============================================================================
`default_nettype none

package clk_div_wiz_pkg;

  typedef enum logic [1:0] {
    LOCKING  = 2'd0,
    LOCKED   = 2'd1,
    RECONFIG = 2'd2
  } state_e;

  function automatic int unsigned clamp_half(input int unsigned x);
    return (x == 0) ? 1 : x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_wiz_chan.sv
// ============================================================================
// clk_div_wiz_chan : one output divider with a glitch-free stop
// Revision: 1.0
// ============================================================================
`default_nettype none

module clk_div_wiz_chan #(
  parameter int HALF_W = 8
) (
  input  logic              clk_in1,
  input  logic              resetn,
  input  logic              i_run,
  input  logic              i_stop_req,
  input  logic [HALF_W-1:0] i_half,
  output logic              o_clk,
  output logic              o_frozen
);

  logic [HALF_W-1:0] r_cnt;
  logic              r_clk;
  logic              w_active;
  logic              w_hit;

  // While stopping, a high phase is allowed to finish so no pulse is clipped.
  assign w_active = i_run | (i_stop_req & r_clk);
  assign w_hit    = (r_cnt == (i_half - HALF_W'(1)));

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
      r_clk <= 1'b0;
    end else if (w_active) begin
      if (w_hit) begin
        r_cnt <= '0;
        r_clk <= ~r_clk;
      end else begin
        r_cnt <= r_cnt + HALF_W'(1);
      end
    end else begin
      r_cnt <= '0;
      r_clk <= 1'b0;
    end
  end

  assign o_clk    = r_clk;
  assign o_frozen = ~r_clk;

endmodule

`default_nettype wire

// File: rtl/clk_div_wiz.sv
// ============================================================================
// clk_div_wiz : behavioral multi-output clock generator with lock/reconfig
// Revision: 1.0
// ============================================================================
`default_nettype none

module clk_div_wiz #(
  parameter int NUM_CH      = 2,
  parameter int HALF_W      = 8,
  parameter int LOCK_CYCLES = 16,
  parameter logic [NUM_CH*HALF_W-1:0] DEFAULT_HALF = {NUM_CH{{{(HALF_W-1){1'b0}}, 1'b1}}},
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in1,
  input  logic              resetn,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_chan,
  input  logic [HALF_W-1:0] cfg_half,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

  import clk_div_wiz_pkg::*;

  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  state_e            r_state;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic [HALF_W-1:0] r_half [NUM_CH];
  logic [CH_W-1:0]   r_pend_chan;
  logic [HALF_W-1:0] r_pend_half;
  logic              r_locked;

  logic              w_run;
  logic              w_stop;
  logic [NUM_CH-1:0] w_clk;
  logic [NUM_CH-1:0] w_frozen;

  assign w_run  = (r_state == LOCKED);
  assign w_stop = (r_state == RECONFIG);

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      r_state     <= LOCKING;
      r_lock_cnt  <= '0;
      r_pend_chan <= '0;
      r_pend_half <= '0;
      r_locked    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_half[i] <= HALF_W'(clamp_half(32'(DEFAULT_HALF[i*HALF_W +: HALF_W])));
      end
    end else begin
      case (r_state)
        LOCKING: begin
          if (r_lock_cnt == LOCK_W'(LOCK_CYCLES - 1)) begin
            r_state  <= LOCKED;
            r_locked <= 1'b1;
          end else begin
            r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
          end
        end
        LOCKED: begin
          if (cfg_valid && r_locked) begin
            r_pend_chan <= cfg_chan;
            r_pend_half <= cfg_half;
            r_state     <= RECONFIG;
            r_locked    <= 1'b0;
          end
        end
        RECONFIG: begin
          // An out-of-range channel matches nothing but still forces a relock.
          if (&w_frozen) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (r_pend_chan == CH_W'(i)) begin
                r_half[i] <= HALF_W'(clamp_half(32'(r_pend_half)));
              end
            end
            r_lock_cnt <= '0;
            r_state    <= LOCKING;
          end
        end
        default: begin
          r_state <= LOCKING;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_wiz_chan #(
      .HALF_W (HALF_W)
    ) u_chan (
      .clk_in1    (clk_in1),
      .resetn     (resetn),
      .i_run      (w_run),
      .i_stop_req (w_stop),
      .i_half     (r_half[g]),
      .o_clk      (w_clk[g]),
      .o_frozen   (w_frozen[g])
    );
  end

  assign clk_out   = w_clk;
  assign locked    = r_locked;
  assign cfg_ready = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_wiz.sv
// ============================================================================
// tb_clk_div_wiz : scoreboard bench for clk_div_wiz lock/reconfig behaviour
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_clk_div_wiz;

  localparam int NCH = 3;
  localparam int HW  = 8;
  localparam int LC  = 16;
  localparam int INF = 32'h3fff_ffff;
  localparam logic [NCH*HW-1:0] DEF = {8'd2, 8'd3, 8'd1};

  logic           clk = 1'b0;
  logic           resetn;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_chan;
  logic [HW-1:0]  cfg_half;
  logic [NCH-1:0] clk_out;
  logic           locked;

  logic           d_ready;
  logic [1:0]     d_clk;
  logic           d_locked;

  // Three channels so that channel index 3 is representable yet out of range.
  clk_div_wiz #(
    .NUM_CH       (NCH),
    .HALF_W       (HW),
    .LOCK_CYCLES  (LC),
    .DEFAULT_HALF (DEF)
  ) u_dut (
    .clk_in1   (clk),
    .resetn    (resetn),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_half  (cfg_half),
    .clk_out   (clk_out),
    .locked    (locked)
  );

  clk_div_wiz u_def (
    .clk_in1   (clk),
    .resetn    (resetn),
    .cfg_valid (1'b0),
    .cfg_ready (d_ready),
    .cfg_chan  (1'b0),
    .cfg_half  (8'd0),
    .clk_out   (d_clk),
    .locked    (d_locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             t;
    logic           lk;
    logic [NCH-1:0] ck;
  } exp_t;

  exp_t q_main[$];
  exp_t q_def[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Closed-form model of the current run / reconfig window.
  int L_run, H_cfg, L_new;
  int halfo[NCH];
  int halfn[NCH];

  function automatic int run_val(input int h, input int k);
    if (k <= 0) return 0;
    return (k / h) % 2;
  endfunction

  function automatic logic [NCH-1:0] model_clk(input int t);
    logic [NCH-1:0] v;
    int kh, fall;
    v = '0;
    for (int i = 0; i < NCH; i++) begin
      if (t < L_run) begin
        v[i] = 1'b0;
      end else if (t < H_cfg) begin
        v[i] = (run_val(halfo[i], t - L_run) != 0);
      end else if (t < L_new) begin
        kh   = H_cfg - L_run;
        fall = L_run + (kh / (2 * halfo[i]) + 1) * 2 * halfo[i];
        v[i] = (run_val(halfo[i], kh) != 0) && (t < fall);
      end else begin
        v[i] = (run_val(halfn[i], t - L_new) != 0);
      end
    end
    return v;
  endfunction

  function automatic logic model_lk(input int t);
    return (t >= L_run) && ((t < H_cfg) || (t >= L_new));
  endfunction

  task automatic model_reset();
    L_run = INF;
    H_cfg = INF;
    L_new = INF;
    for (int i = 0; i < NCH; i++) begin
      halfo[i] = (DEF[i*HW +: HW] == 0) ? 1 : int'(DEF[i*HW +: HW]);
      halfn[i] = halfo[i];
    end
  endtask

  task automatic plan_cfg(input int h, input int chan, input int hv);
    int z, kh, fall;
    H_cfg = h;
    for (int i = 0; i < NCH; i++) halfn[i] = halfo[i];
    if (chan < NCH) halfn[chan] = (hv == 0) ? 1 : hv;
    z  = h;
    kh = h - L_run;
    for (int i = 0; i < NCH; i++) begin
      if (run_val(halfo[i], kh) != 0) begin
        fall = L_run + (kh / (2 * halfo[i]) + 1) * 2 * halfo[i];
        if (fall > z) z = fall;
      end
    end
    L_new = z + 1 + LC;
  endtask

  task automatic commit_cfg();
    L_run = L_new;
    for (int i = 0; i < NCH; i++) halfo[i] = halfn[i];
    H_cfg = INF;
    L_new = INF;
  endtask

  task automatic push_range(input int t0, input int t1);
    exp_t e;
    for (int t = t0; t <= t1; t++) begin
      e.t  = t;
      e.lk = model_lk(t);
      e.ck = model_clk(t);
      q_main.push_back(e);
    end
  endtask

  task automatic push_def(input int t0, input int t1);
    exp_t e;
    for (int t = t0; t <= t1; t++) begin
      e.t  = t;
      e.lk = (t >= L_run);
      e.ck = '0;
      e.ck[0] = (t >= L_run) && (run_val(1, t - L_run) != 0);
      e.ck[1] = e.ck[0];
      q_def.push_back(e);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drive_cfg(input int h, input int chan, input int hv);
    wait_until(h - 1);
    cfg_valid = 1'b1;
    cfg_chan  = 2'(chan);
    cfg_half  = HW'(hv);
    wait_until(h);
    cfg_valid = 1'b0;
  endtask

  function automatic int pick_h(input int rise_ch);
    int h;
    h = cyc + 2;
    if (h < L_run + 1) h = L_run + 1;
    if (rise_ch >= 0) begin
      while (((h - L_run) % (2 * halfo[rise_ch])) != halfo[rise_ch]) h++;
    end
    return h;
  endfunction

  task automatic do_cfg(input int chan, input int hv, input int rise_ch);
    int h;
    h = pick_h(rise_ch);
    plan_cfg(h, chan, hv);
    push_range(cyc + 1, L_new + 40);
    drive_cfg(h, chan, hv);
    wait_until(L_new + 40);
    commit_cfg();
  endtask

  // Scoreboard: every queued cycle is compared on the falling edge after it.
  always @(negedge clk) begin
    exp_t e;
    while (q_main.size() > 0 && q_main[0].t <= cyc) begin
      e = q_main.pop_front();
      n_chk++;
      if (e.t != cyc) begin
        n_fail++;
        $display("FAIL main_stale: entry for cycle %0d seen at cycle %0d", e.t, cyc);
      end else begin
        if ({locked, cfg_ready} !== {e.lk, e.lk}) begin
          n_fail++;
          $display("FAIL main_lock cyc=%0d: locked=%b cfg_ready=%b, expected %b", cyc, locked, cfg_ready, e.lk);
        end
        n_chk++;
        if (clk_out !== e.ck) begin
          n_fail++;
          $display("FAIL main_clk cyc=%0d: clk_out=%b, expected %b", cyc, clk_out, e.ck);
        end
      end
    end
    while (q_def.size() > 0 && q_def[0].t <= cyc) begin
      e = q_def.pop_front();
      n_chk++;
      if (e.t != cyc || {d_locked, d_ready, d_clk} !== {e.lk, e.lk, e.ck[1:0]}) begin
        n_fail++;
        $display("FAIL def_out cyc=%0d: locked=%b ready=%b clk=%b, expected %b/%b", cyc, d_locked, d_ready, d_clk, e.lk, e.ck[1:0]);
      end
    end
  end

  task automatic test_reset();
    push_range(cyc + 1, 4);
    push_def(cyc + 1, 4);
    wait_until(4);
    #1 resetn = 1'b1;
    L_run = cyc + LC;
    push_range(cyc + 1, L_run + 24);
    push_def(cyc + 1, L_run + 24);
    wait_until(L_run + 24);
  endtask

  task automatic test_reconfig();
    do_cfg(1, 5, 1);
  endtask

  task automatic test_half_zero();
    do_cfg(0, 2, -1);
    do_cfg(0, 0, -1);
  endtask

  task automatic test_bad_chan();
    do_cfg(3, 9, -1);
  endtask

  task automatic test_backpressure();
    int t_end;
    wait_until(cyc + 1);
    #1 resetn = 1'b0;
    model_reset();
    push_range(cyc + 1, cyc + 3);
    t_end = cyc + 3;
    wait_until(t_end);
    #1 resetn = 1'b1;
    cfg_valid = 1'b1;
    cfg_chan  = 2'd2;
    cfg_half  = 8'd4;
    L_run = cyc + LC;
    plan_cfg(L_run + 1, 2, 4);
    push_range(cyc + 1, L_new + 40);
    wait_until(L_run + 1);
    cfg_valid = 1'b0;
    wait_until(L_new + 40);
    commit_cfg();
  endtask

  task automatic test_reset_mid_reconfig();
    int h, t_end;
    h = pick_h(1);
    plan_cfg(h, 1, 7);
    push_range(cyc + 1, h);
    drive_cfg(h, 1, 7);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    n_chk++;
    if (clk_out !== '0 || locked !== 1'b0 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: clk_out=%b locked=%b cfg_ready=%b, expected all 0", clk_out, locked, cfg_ready);
    end
    model_reset();
    push_range(cyc, cyc + 3);
    t_end = cyc + 3;
    wait_until(t_end);
    #1 resetn = 1'b1;
    L_run = cyc + LC;
    push_range(cyc + 1, L_run + 30);
    wait_until(L_run + 30);
  endtask

  initial begin
    resetn    = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_half  = '0;
    model_reset();
    test_reset();
    test_reconfig();
    test_half_zero();
    test_bad_chan();
    test_backpressure();
    test_reset_mid_reconfig();
    repeat (3) @(negedge clk);
    n_chk++;
    if (q_main.size() != 0 || q_def.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", q_main.size(), q_def.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
